// File: rtl/menu_sequencer.sv
// menu_sequencer: startup-screen sequencing and hand-off into gameplay.
// Tracks the selected mode, the cursor blink, the post-entry input lockout
// and the one-cycle launch pulse into the game core. Every output is a register.
// Optional build macro MENU_TIMEOUT_EN: after TIMEOUT_FRAMES idle frames in the
// menu the sequencer auto-launches a 1-player demo game.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_LOCK   | menu shown, button edges ignored until the lockout expires
// S_MENU   | menu shown, up/down move the cursor, select launches
// S_LAUNCH | selection frozen, waiting for the next frame to start the game
// S_GAME   | gameplay running, menu hidden until game_over
module menu_sequencer #(
  parameter int LOCKOUT_FRAMES = 15,
  parameter int BLINK_FRAMES   = 30,
  parameter int TIMEOUT_FRAMES = 600,
  parameter int CNT_W          = 10
) (
  input  logic clk_0,
  input  logic rst,
  input  logic frame_tick,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_select,
  input  logic game_over,
  output logic show_menu,
  output logic sel_mode,
  output logic highlight_on,
  output logic game_start,
  output logic mode,
  output logic demo
);

  typedef enum logic [1:0] {S_LOCK, S_MENU, S_LAUNCH, S_GAME} state_t;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counter width must hold every frame count without wrapping.
  if ((2 ** CNT_W) <= LOCKOUT_FRAMES || (2 ** CNT_W) <= BLINK_FRAMES ||
      (2 ** CNT_W) <= TIMEOUT_FRAMES) begin : g_cnt_w_check
    $error("menu_sequencer: CNT_W too narrow for the frame counts");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_nxt;
  logic [CNT_W-1:0] blink_cnt, blink_nxt;
  logic [2:0]       prev_btn;
  logic [2:0]       btn_now;
  logic [2:0]       btn_edge;
  logic             show_nxt, sel_nxt, hl_nxt, start_nxt, mode_nxt;
  logic             move_up, move_dn;
  logic [CNT_W-1:0] blink_adv;
  logic             hl_adv;

`ifdef MENU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
  logic [CNT_W-1:0] idle_cnt, idle_nxt;
  logic             demo_nxt;
`else
  assign demo = 1'b0;
`endif

  // Bit order {select, down, up}; an edge is usable in the cycle it is seen.
  assign btn_now  = {btn_select, btn_down, btn_up};
  assign btn_edge = btn_now & ~prev_btn;
  assign move_up  = btn_edge[0] & ~btn_edge[1];
  assign move_dn  = btn_edge[1] & ~btn_edge[0];

  // Blink advance applied on a frame tick in the states that blink.
  assign hl_adv    = (blink_cnt == BLINK_LAST) ? ~highlight_on : highlight_on;
  assign blink_adv = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + ONE;

  // State, counters and registered outputs; prev_btn resets high so a
  // button held through reset does not count as a press.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      state        <= S_LOCK;
      lock_cnt     <= '0;
      blink_cnt    <= '0;
      prev_btn     <= 3'b111;
      show_menu    <= 1'b1;
      sel_mode     <= 1'b0;
      highlight_on <= 1'b1;
      game_start   <= 1'b0;
      mode         <= 1'b0;
`ifdef MENU_TIMEOUT_EN
      idle_cnt     <= '0;
      demo         <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      lock_cnt     <= lock_nxt;
      blink_cnt    <= blink_nxt;
      prev_btn     <= btn_now;
      show_menu    <= show_nxt;
      sel_mode     <= sel_nxt;
      highlight_on <= hl_nxt;
      game_start   <= start_nxt;
      mode         <= mode_nxt;
`ifdef MENU_TIMEOUT_EN
      idle_cnt     <= idle_nxt;
      demo         <= demo_nxt;
`endif
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_cnt;
    blink_nxt = blink_cnt;
    show_nxt  = show_menu;
    sel_nxt   = sel_mode;
    hl_nxt    = highlight_on;
    start_nxt = 1'b0;
    mode_nxt  = mode;
`ifdef MENU_TIMEOUT_EN
    idle_nxt  = idle_cnt;
    demo_nxt  = demo;
`endif
    case (state)
      S_LOCK: begin
        show_nxt = 1'b1;
        if (frame_tick) begin
          hl_nxt    = hl_adv;
          blink_nxt = blink_adv;
          if (lock_cnt == LOCK_LAST) begin
            state_nxt = S_MENU;
            lock_nxt  = '0;
          end else begin
            lock_nxt = lock_cnt + ONE;
          end
        end
      end
      S_MENU: begin
        show_nxt = 1'b1;
        if (btn_edge[2]) begin
          state_nxt = S_LAUNCH;
          hl_nxt    = 1'b1;
`ifdef MENU_TIMEOUT_EN
          idle_nxt  = '0;
`endif
        end
`ifdef MENU_TIMEOUT_EN
        else if (btn_edge == 3'b000 && frame_tick && idle_cnt == IDLE_LAST) begin
          state_nxt = S_LAUNCH;
          sel_nxt   = 1'b0;
          demo_nxt  = 1'b1;
          hl_nxt    = 1'b1;
          idle_nxt  = '0;
        end
`endif
        else begin
          // A real cursor move restarts the blink with the cursor visible.
          if ((move_up && sel_mode) || (move_dn && !sel_mode)) begin
            sel_nxt   = move_dn;
            hl_nxt    = 1'b1;
            blink_nxt = '0;
          end else if (frame_tick) begin
            hl_nxt    = hl_adv;
            blink_nxt = blink_adv;
          end
`ifdef MENU_TIMEOUT_EN
          if (btn_edge != 3'b000) idle_nxt = '0;
          else if (frame_tick)    idle_nxt = idle_cnt + ONE;
`endif
        end
      end
      S_LAUNCH: begin
        show_nxt = 1'b1;
        hl_nxt   = 1'b1;
        if (frame_tick) begin
          state_nxt = S_GAME;
          start_nxt = 1'b1;
          mode_nxt  = sel_mode;
          show_nxt  = 1'b0;
          hl_nxt    = 1'b0;
        end
      end
      S_GAME: begin
        show_nxt = 1'b0;
        hl_nxt   = 1'b0;
        // A coincident frame tick is deliberately not counted here.
        if (game_over) begin
          state_nxt = S_LOCK;
          lock_nxt  = '0;
          blink_nxt = '0;
          show_nxt  = 1'b1;
          hl_nxt    = 1'b1;
`ifdef MENU_TIMEOUT_EN
          demo_nxt  = 1'b0;
`endif
        end
      end
      default: state_nxt = S_LOCK;
    endcase
  end

endmodule

// File: doc/menu_sequencer.md
Name: menu_sequencer

Overview:
- Sequences the startup screen and the hand-off into gameplay.
- Owns the menu state: which mode is selected, cursor blink timing, input lockout, and the launch handshake into the game core.
- Sits between the debounced button inputs / VGA frame timing and both the startup text overlay (show_menu, cursor highlight) and the game logic (game_start, mode).
- Runs in the pixel clock domain clk_0.

Parameters:
- LOCKOUT_FRAMES, 15: frames after entering the menu during which button edges are ignored.
- BLINK_FRAMES, 30: frames per cursor half-period (on time = off time).
- TIMEOUT_FRAMES, 600: idle frames before auto-launch. Used only with MENU_TIMEOUT_EN.
- CNT_W, 10: width of the frame counters. Must satisfy 2^CNT_W > max(LOCKOUT_FRAMES, BLINK_FRAMES, TIMEOUT_FRAMES).

Ports:
- clk_0  in  1  pixel clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank).
- btn_up  in  1  debounced level, active-high.
- btn_down  in  1  debounced level, active-high.
- btn_select  in  1  debounced level, active-high.
- game_over  in  1  one-cycle pulse from game core.
- show_menu  out  1  high while startup text is to be drawn.
- sel_mode  out  1  cursor position: 0 = 1 PLAYER, 1 = 2 PLAYERS.
- highlight_on  out  1  cursor/highlight visible this frame.
- game_start  out  1  one-cycle pulse launching the game.
- mode  out  1  mode latched at launch; stable throughout S_GAME.
- demo  out  1  high if the launch came from the timeout.

Behaviour:
- All outputs are registered. Reset is synchronous, active-high, and overrides everything.
- Reset values: state = S_LOCK; show_menu = 1; sel_mode = 0; highlight_on = 1; game_start = 0; mode = 0; demo = 0; all counters = 0.
- Edge detect:
  - prev_btn registers reset to 3'b111, so a button held through reset does not produce an edge.
  - An edge is btn & ~prev_btn, and is used in the same cycle it is detected.
- States:
  - S_LOCK: show_menu = 1. lock_cnt increments on each frame_tick. When a frame_tick arrives with lock_cnt = LOCKOUT_FRAMES-1, go to S_MENU and clear lock_cnt. All edges are ignored in this state.
  - S_MENU: show_menu = 1. Edges are handled with priority select > up/down.
    - select edge: go to S_LAUNCH.
    - up edge alone: sel_mode = 0.
    - down edge alone: sel_mode = 1.
    - Selection saturates at each end and never wraps.
    - up and down edges in the same cycle: no change.
    - Any sel_mode change forces highlight_on = 1 and clears blink_cnt.
  - S_LAUNCH: show_menu = 1, highlight_on held at 1. Wait for the next frame_tick. On that tick, in the same cycle: game_start = 1 for exactly one cycle, mode <= sel_mode, state -> S_GAME. Buttons are ignored.
  - S_GAME: show_menu = 0, highlight_on = 0. A game_over pulse returns to S_LOCK with lock_cnt = 0. sel_mode is retained so the cursor reappears on the previous choice, and highlight_on is set to 1. demo clears on leaving S_GAME.
- Blink: applies in S_LOCK and S_MENU only.
  - blink_cnt increments on each frame_tick.
  - On a tick with blink_cnt = BLINK_FRAMES-1: toggle highlight_on and clear blink_cnt.
- Simultaneity: game_over and frame_tick in the same cycle in S_GAME → go to S_LOCK; that tick is not counted.
- Counter arithmetic is CNT_W bits unsigned. Comparisons are against the parameter minus 1, so counters never wrap.

Optional Feature:
- Macro MENU_TIMEOUT_EN.
- Defined:
  - idle_cnt increments on each frame_tick in S_MENU and clears on any button edge.
  - On a tick with idle_cnt = TIMEOUT_FRAMES-1: sel_mode <= 0, demo <= 1, go to S_LAUNCH.
  - A select edge in the same cycle takes priority; demo stays 0.
- Not defined: no idle_cnt logic; demo is tied to 0; the menu waits indefinitely.

Test Plan (benches use LOCKOUT_FRAMES=2, BLINK_FRAMES=3, TIMEOUT_FRAMES=5):
- Reset with btn_select held high, then 4 frame_ticks → no S_LAUNCH entry; show_menu=1, sel_mode=0, game_start never asserts.
- After lockout, pulse btn_down, then btn_down again, then btn_up → sel_mode goes 1, stays 1 (saturates), then returns to 0; highlight_on=1 right after each change.
- In S_MENU, 6 frame_ticks with no input → highlight_on toggles after tick 3 and again after tick 6.
- Edge on btn_select and btn_down in the same cycle with sel_mode=0 → S_LAUNCH with sel_mode=0. At the next frame_tick: game_start high for 1 cycle, mode=0, show_menu=0 the following cycle.
- In S_GAME with mode=1, pulse game_over → show_menu=1, sel_mode=1. A btn_select edge during the next 2 ticks is ignored; after the lockout, a select edge launches again.
- With MENU_TIMEOUT_EN defined, sel_mode=1 and 5 idle ticks in S_MENU → sel_mode=0, demo=1. At the next frame_tick: game_start pulses, mode=0.
